restoring_division: RTL and testbench

//  - Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//  - Produces one quotient bit per clock, MSB first; 32 iterations at default width.
//  - Standalone arithmetic unit for the CPU datapath (DIV/REM ops); start/done handshake to the controller.

---
 rtl/restoring_division.sv | 106 ++++++++++
 tb/tb_restoring_division.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/restoring_division.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// A start/done handshake sits around a three-state IDLE/RUN/FINISH controller.
module restoring_division #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    count;

  logic             accept;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // Working remainder is held in WIDTH bits: after each restore step it is
  // strictly below the divisor, so only the shifted value needs the extra bit.
  always_comb begin
    r_sh = {r_q, q_q[WIDTH-1]};
    diff = r_sh - {1'b0, d_q};
    if (diff[WIDTH] == 1'b0) begin
      r_next = diff[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_sh[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // A start in FINISH is accepted just like one in IDLE.
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == FINISH);

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, FINISH: begin
        if (accept) next_state = (divisor == '0) ? FINISH : RUN;
        else        next_state = IDLE;
      end
      RUN:     if (count == LAST) next_state = FINISH;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_q   <= divisor;
      q_q   <= dividend;
      r_q   <= '0;
      count <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      q_q   <= q_next;
      r_q   <= r_next;
      count <= count + 1'b1;
      if (count == LAST) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_division.sv
// Self-checking bench for restoring_division: directed vector table, reset and
// handshake sequences, then back-to-back random operations.
module tb_restoring_division;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ops_started = 0;

  restoring_division #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where done is high
  // (or after a bounded number of cycles). lat counts rising edges from E0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    ops_started++;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end while (!done && lat < 100);
  endtask

  initial begin
    int lat;
    int dc;
    logic [31:0] a, b;

    vecs[0] = '{32'd32,         32'd8,          32'd4,          32'd0,   1'b0, 33};
    vecs[1] = '{32'd124432,     32'd1226,       32'd101,        32'd606, 1'b0, 33};
    vecs[2] = '{32'd81,         32'd2,          32'd40,         32'd1,   1'b0, 33};
    vecs[3] = '{32'd3807872197, 32'd25,         32'd152314887,  32'd22,  1'b0, 33};
    vecs[4] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,   1'b0, 33};
    vecs[5] = '{32'd100,        32'd0,          32'hFFFFFFFF,   32'd100, 1'b1, 1};
    vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0, 33};
    vecs[7] = '{32'd5,          32'd7,          32'd0,          32'd5,   1'b0, 33};
    vecs[8] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,   1'b0, 33};
    vecs[9] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,   1'b1, 1};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset quotient",  quotient,  32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset busy",      {31'd0, busy}, 32'd0);
    check("reset done",      {31'd0, done}, 32'd0);
    check("reset dbz",       {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i),   lat,       vecs[i].exp_lat);
      check($sformatf("vec%0d quotient", i),  quotient,  vecs[i].exp_q);
      check($sformatf("vec%0d remainder", i), remainder, vecs[i].exp_r);
      check($sformatf("vec%0d dbz", i),       {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
      check($sformatf("vec%0d busy at done", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d result held", i), quotient, vecs[i].exp_q);
    end

    // Reset in the middle of RUN aborts the operation with no done pulse.
    run_op_abort: begin
      start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("busy after start", {31'd0, busy}, 32'd1);
      repeat (10) @(negedge clk);
      dc = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort quotient",  quotient,  32'd0);
      check("abort remainder", remainder, 32'd0);
      check("abort busy",      {31'd0, busy}, 32'd0);
      check("abort done",      {31'd0, done}, 32'd0);
      check("abort dbz",       {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort no done", done_cnt, dc);
    end

    // Start pulses and operand changes while busy are ignored.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
    ops_started++;
    @(posedge clk); @(negedge clk);
    lat = 1;
    for (int k = 0; k < 40 && !done; k++) begin
      start    = (k % 3 == 0);
      dividend = 32'd55 + k;
      divisor  = 32'd2;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("busy-start latency",   lat,       33);
    check("busy-start quotient",  quotient,  32'd142);
    check("busy-start remainder", remainder, 32'd6);
    @(negedge clk);

    // Back-to-back random operations; each new start lands in FINISH.
    for (int n = 0; n < 200; n++) begin
      a = $random;
      b = $random;
      if (n % 4 == 1) b = b >> (b[4:0]);
      if (b == 0) b = 32'd1;
      run_op(a, b, lat);
      check($sformatf("rand%0d latency", n), lat, 33);
      check($sformatf("rand%0d quotient %0d/%0d", n, a, b), quotient, a / b);
      check($sformatf("rand%0d remainder", n), remainder, a % b);
    end
    @(negedge clk);
    @(negedge clk);
    check("done count", done_cnt, ops_started);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
